// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response FSM state type used by the
// block-RAM slave and other AHB slaves in this slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite bus signals between a master (or interconnect) and one slave.
// Handshake: an address phase completes on a rising edge where HSEL, HREADY and
// HTRANS[1] are all high; its data phase ends on the next edge with HREADY high.
interface ahb_bram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_byte_strobe.sv
// Byte-lane strobe decode for an AHB transfer; flags size/alignment
// combinations the slave must answer with ERROR.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strobe,
  output logic       illegal
);

  always_comb begin
    strobe  = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            strobe  = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  strobe  = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a dual-port block RAM with a
// 1-cycle registered read port; forwards write data to an immediately following read.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [3:0]            ram_wea,
  output logic [31:0]           ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb,
  output resp_state_t           dbg_state
);

  logic [ADDR_WIDTH-1:0] addr_word;
  logic                  accept;
  logic [3:0]            strobe;
  logic                  illegal;

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_strb;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;
  resp_state_t           state;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [31:0]           hrdata;

  // Upper address bits alias onto the RAM; HTRANS[0] only separates NONSEQ/SEQ.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

  assign addr_word = bus.HADDR[ADDR_WIDTH+1:2];
  assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  ahb_byte_strobe u_strobe (
    .hsize   (bus.HSIZE),
    .addr_lo (bus.HADDR[1:0]),
    .strobe  (strobe),
    .illegal (illegal)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_strb     <= 4'b0000;
      fwd_mask    <= 4'b0000;
      fwd_data    <= 32'h0;
      state       <= ST_OKAY;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      if (bus.HREADY) begin
        wr_pend <= accept & bus.HWRITE & ~illegal;
        if (accept) begin
          wr_addr <= addr_word;
          wr_strb <= strobe;
        end
        // A read hitting the word being written this cycle cannot see it in
        // the RAM yet, so capture the written lanes for its data phase.
        if (accept & ~bus.HWRITE & ~illegal & wr_pend & (wr_addr == addr_word)) begin
          fwd_mask <= ram_wea;
          fwd_data <= bus.HWDATA;
        end else begin
          fwd_mask <= 4'b0000;
        end
      end

      case (state)
        ST_OKAY: begin
          if (accept & illegal) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        ST_ERR2: begin
          if (accept & illegal) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            state       <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        default: begin
          state       <= ST_OKAY;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  always_comb begin
    hrdata = ram_doutb;
    for (int i = 0; i < 4; i++) begin
      if (fwd_mask[i]) hrdata[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

  assign ram_addra     = wr_addr;
  assign ram_wea       = wr_pend ? wr_strb : 4'b0000;
  assign ram_dina      = bus.HWDATA;
  assign ram_addrb     = addr_word;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl: drives AHB transfers, models the block RAM,
// and checks every data-phase response against a queue of expected results.
module tb_ahb_bram_ctrl;
  import ahb_pkg::*;

  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_bram_ctrl_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  logic [AW-1:0] ram_addra;
  logic [AW-1:0] ram_addrb;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_dina;
  logic [31:0]   ram_doutb = 32'h0;
  resp_state_t   dbg_state;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .ram_addra (ram_addra),
    .ram_wea   (ram_wea),
    .ram_dina  (ram_dina),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .dbg_state (dbg_state)
  );

  // Block RAM: byte-enabled write port, registered read port (read-before-write).
  logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    ram_doutb <= mem[ram_addrb];
  end

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {err, is_read, rdata}
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wdata_q = 32'h0;
  logic        drv_sel = 1'b1;
  logic        wea_watch = 1'b0;
  logic        rdy_watch = 1'b0;
  logic        wea_chk_en = 1'b0;
  logic [3:0]  wea_exp = 4'b0000;
  logic        dp = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", nm, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rd, input string nm);
    logic rdy;
    int   tries;
    bus.HSEL   = drv_sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    bus.HWDATA = wdata_q;
    if (drv_sel && trans[1]) begin
      exp_q.push_back({exp_err, ~wr, exp_rd});
      nm_q.push_back(nm);
    end
    tries = 0;
    do begin
      @(negedge HCLK);
      if (wea_chk_en) begin
        check("wea_strobe", {28'h0, ram_wea}, {28'h0, wea_exp});
        wea_chk_en = 1'b0;
      end
      rdy = bus.HREADYOUT;
      @(posedge HCLK);
      #1;
      tries++;
    end while (!rdy && tries < 20);
    if (!rdy) begin
      errors++;
      $display("FAIL %s: address phase not accepted within 20 cycles", nm);
    end
    wdata_q = wdata;
  endtask

  task automatic idle();
    issue(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  task automatic wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data,
                    input string nm);
    issue(HTRANS_NONSEQ, 1'b1, size, addr, data, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    issue(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0, 1'b0, exp, nm);
  endtask

  task automatic bad(input logic [2:0] size, input logic [31:0] addr, input string nm);
    issue(HTRANS_NONSEQ, 1'b1, size, addr, 32'hFFFF_FFFF, 1'b1, 32'h0, nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge HCLK) begin
    logic [33:0] e;
    string       n;
    if (!HRESETn) begin
      dp = 1'b0;
    end else begin
      if (wea_watch) check("wea_quiet", {28'h0, ram_wea}, 32'h0);
      if (rdy_watch) check("hreadyout_high", {31'h0, bus.HREADYOUT}, 32'h1);
      if (dp) begin
        if (!bus.HREADYOUT) begin
          checks++;
          if (exp_q.size() == 0 || !exp_q[0][33] || bus.HRESP !== HRESP_ERROR) begin
            errors++;
            $display("FAIL err1_phase: got hresp=%0d, expected an ERROR first cycle", bus.HRESP);
          end
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response: got a data phase with nothing expected");
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          check({n, "_resp"}, {31'h0, bus.HRESP}, {31'h0, e[33]});
          if (e[32] && !e[33]) check({n, "_rdata"}, bus.HRDATA, e[31:0]);
        end
      end
      if (bus.HREADYOUT) dp = bus.HSEL & bus.HTRANS[1];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    bus.HSIZE = HSIZE_WORD; bus.HADDR = 32'h0; bus.HWDATA = 32'h0;

    repeat (3) @(posedge HCLK);
    #1;
    check("reset_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("reset_hresp",     {31'h0, bus.HRESP},     32'h0);
    check("reset_wea",       {28'h0, ram_wea},       32'h0);
    check("reset_state",     {30'h0, dbg_state},     {30'h0, ST_OKAY});
    check("reset_hrdata",    bus.HRDATA,             32'h0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write, idle, read back.
    wr(HSIZE_WORD, 32'h010, 32'hDEAD_BEEF, "w_010");
    idle();
    rd(32'h010, 32'hDEAD_BEEF, "r_010");

    // Byte write into lane 3 over an existing word.
    wr(HSIZE_WORD, 32'h010, 32'h1122_3344, "w_010b");
    wr(HSIZE_BYTE, 32'h013, 32'hAA00_0000, "wb_013");
    wea_chk_en = 1'b1; wea_exp = 4'b1000;
    idle();
    rd(32'h010, 32'hAA22_3344, "r_010b");

    // Write immediately followed by a read of the same word.
    wr(HSIZE_HALF, 32'h022, 32'hBBBB_0000, "wh_022");
    rd(32'h020, 32'hBBBB_0000, "r_fwd_half");
    wr(HSIZE_WORD, 32'h020, 32'h5566_7788, "w_020");
    rd(32'h020, 32'h5566_7788, "r_fwd_word");

    // Unselected slave ignores a write.
    drv_sel = 1'b0;
    idle();
    wea_watch = 1'b1;
    wr(HSIZE_WORD, 32'h010, 32'hFFFF_FFFF, "w_unsel");
    drv_sel = 1'b1;
    idle();
    wea_watch = 1'b0;
    rd(32'h010, 32'hAA22_3344, "r_unsel");

    // Illegal transfers: misaligned halfword, then HSIZE=3 back-to-back.
    wr(HSIZE_WORD, 32'h000, 32'h0102_0304, "w_000");
    idle();
    wea_watch = 1'b1;
    bad(HSIZE_HALF, 32'h001, "bad_half");
    bad(3'd3,       32'h000, "bad_size3");
    idle();
    idle();
    wea_watch = 1'b0;
    rd(32'h000, 32'h0102_0304, "r_after_err");

    // Reset released straight into a write/read stream.
    @(negedge HCLK) HRESETn = 1'b0;
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    wdata_q   = 32'h0;
    rdy_watch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr(HSIZE_WORD, 32'h100 + 4*i, 32'hC0DE_0000 + i, "w_stream");
      rd(32'h100 + 4*i, 32'hC0DE_0000 + i, "r_stream");
    end
    idle();
    rdy_watch = 1'b0;
    idle();
    rd(32'h104, 32'hC0DE_0001, "r_stream_ram");

    // Reset pulse during a write data phase drops the write.
    wr(HSIZE_WORD, 32'h040, 32'h1234_5678, "w_040");
    idle();
    idle();
    wr(HSIZE_WORD, 32'h040, 32'hCAFE_F00D, "w_040_drop");
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = wdata_q;
    #1 check("wea_before_reset", {28'h0, ram_wea}, 32'hF);
    #2 HRESETn = 1'b0;
    #1 check("wea_async_reset", {28'h0, ram_wea}, 32'h0);
    exp_q.delete();
    nm_q.delete();
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("state_after_reset", {30'h0, dbg_state}, {30'h0, ST_OKAY});
    wdata_q = 32'h0;
    rd(32'h040, 32'h1234_5678, "r_040_kept");
    idle();
    idle();

    check("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
